// File: rtl/count_defs.sv
// Shared definitions for the count monitor.
// State encodings and default widths.
package count_defs;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ERR_W = 8;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

endpackage

// File: rtl/count_predictor.sv
// Next-value predictor for the observed counter.
// Mirrors the counter's own update rule on the sampled inputs.
module count_predictor
   import count_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             cnt_reset_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] count_i,
   output logic [WIDTH-1:0] pred_o
);

   // cnt_reset wins over enable; prediction is built from the observed count
   always_comb begin
      pred_o = count_i;
      if (cnt_reset_i) begin
         pred_o = '0;
      end else if (enable_i) begin
         pred_o = count_i + WIDTH'(1);
      end
   end

endmodule

// File: rtl/count_monitor.sv
// Lock-and-track monitor for an up-counter.
// Locks after LOCK_N good predictions, flags mismatches and wraps.
module count_monitor
   import count_defs::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ERR_W  = DEF_ERR_W,
   parameter int LOCK_N = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cnt_reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] count,
   output logic             locked,
   output logic             mismatch,
   output logic             wrap,
   output logic [WIDTH-1:0] expected,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [3:0] LOCK_T = 4'(LOCK_N);

   state_e           state_q, state_d;
   logic [3:0]       streak_q, streak_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             lock_q, lock_d;
   logic             mm_q, mm_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] pred;
   logic             hit;

   count_predictor #(
      .WIDTH(WIDTH)
   ) u_pred (
      .cnt_reset_i(cnt_reset),
      .enable_i   (enable),
      .count_i    (count),
      .pred_o     (pred)
   );

   assign hit = (count == exp_q);

   // State and output registers; reset discards everything silently
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_UNLOCKED;
         streak_q <= '0;
         exp_q    <= '0;
         err_q    <= '0;
         lock_q   <= 1'b0;
         mm_q     <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         exp_q    <= exp_d;
         err_q    <= err_d;
         lock_q   <= lock_d;
         mm_q     <= mm_d;
         wrap_q   <= wrap_d;
      end
   end

   // Next state, streak, error count and pulse outputs
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      exp_d    = pred;
      err_d    = err_q;
      mm_d     = 1'b0;
      wrap_d   = 1'b0;
      unique case (state_q)
         ST_UNLOCKED: begin
            streak_d = '0;
            state_d  = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (hit) begin
               if (streak_q + 4'd1 >= LOCK_T) begin
                  streak_d = '0;
                  state_d  = ST_LOCKED;
               end else begin
                  streak_d = streak_q + 4'd1;
               end
            end else begin
               streak_d = '0;
            end
         end
         ST_LOCKED: begin
            wrap_d = (&count) && enable && !cnt_reset;
            if (!hit) begin
               mm_d     = 1'b1;
               streak_d = '0;
               state_d  = ST_ACQUIRE;
               if (err_q != {ERR_W{1'b1}}) begin
                  err_d = err_q + ERR_W'(1);
               end
            end
         end
         default: begin
            state_d  = ST_UNLOCKED;
            streak_d = '0;
         end
      endcase
      lock_d = (state_d == ST_LOCKED);
   end

   assign locked    = lock_q;
   assign mismatch  = mm_q;
   assign wrap      = wrap_q;
   assign expected  = exp_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed vector bench for count_monitor.
// Main table on an ERR_W=8 instance, saturation run on ERR_W=2.
module tb_count_monitor;

   typedef struct {
      logic       rst;
      logic       cr;
      logic       en;
      logic [3:0] cnt;
      logic       lk;
      logic       mm;
      logic       wr;
      logic [3:0] ex;
      int         er;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, cnt_reset, enable;
   logic [3:0] count;
   logic       locked, mismatch, wrap;
   logic [3:0] expected;
   logic [7:0] err_count;

   logic       reset2, cnt_reset2, enable2;
   logic [3:0] count2;
   logic       locked2, mismatch2, wrap2;
   logic [3:0] expected2;
   logic [1:0] err_count2;

   int total = 0;
   int bad   = 0;
   vec_t tv[$];

   always #5 clk = ~clk;

   count_monitor #(.WIDTH(4), .ERR_W(8), .LOCK_N(2)) dut (
      .clk(clk), .reset(reset), .cnt_reset(cnt_reset),
      .enable(enable), .count(count), .locked(locked),
      .mismatch(mismatch), .wrap(wrap), .expected(expected),
      .err_count(err_count)
   );

   count_monitor #(.WIDTH(4), .ERR_W(2), .LOCK_N(2)) dut2 (
      .clk(clk), .reset(reset2), .cnt_reset(cnt_reset2),
      .enable(enable2), .count(count2), .locked(locked2),
      .mismatch(mismatch2), .wrap(wrap2), .expected(expected2),
      .err_count(err_count2)
   );

   task automatic cmp(input string nm, input int idx,
                      input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s row %0d: got %0d want %0d", nm, idx, act, req);
      end
   endtask

   task automatic add(input logic rst, input logic cr, input logic en,
                      input int cnt, input logic lk, input logic mm,
                      input logic wr, input int ex, input int er);
      vec_t v;
      v.rst = rst; v.cr = cr; v.en = en; v.cnt = 4'(cnt);
      v.lk = lk; v.mm = mm; v.wr = wr; v.ex = 4'(ex); v.er = er;
      tv.push_back(v);
   endtask

   task automatic step2(input logic rst, input logic cr,
                        input logic en, input int cnt);
      reset2 = rst; cnt_reset2 = cr; enable2 = en; count2 = 4'(cnt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 0; cnt_reset = 0; enable = 0; count = 0;
      reset2 = 0; cnt_reset2 = 0; enable2 = 0; count2 = 0;

      // reset, then cnt_reset pulse, then 20 enabled counts
      add(0, 0, 0, 9, 0, 0, 0, 0, 0);
      add(1, 1, 0, 9, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 1, 0);
      add(1, 0, 1, 1, 1, 0, 0, 2, 0);
      for (int c = 2; c < 20; c++)
         add(1, 0, 1, c % 16, 1, 0, (c % 16) == 15, (c + 1) % 16, 0);
      // glitch 5 -> 9 while locked, then relock
      add(1, 0, 1, 4, 1, 0, 0, 5, 0);
      add(1, 0, 1, 9, 0, 1, 0, 10, 1);
      add(1, 0, 1, 10, 0, 0, 0, 11, 1);
      add(1, 0, 1, 11, 1, 0, 0, 12, 1);
      for (int c = 12; c < 23; c++)
         add(1, 0, 1, c % 16, 1, 0, (c % 16) == 15, (c + 1) % 16, 1);
      // enable low for 10 samples at count 7
      for (int k = 0; k < 10; k++)
         add(1, 0, 0, 7, 1, 0, 0, 7, 1);
      // cnt_reset at 12 with enable high
      for (int c = 7; c < 12; c++)
         add(1, 0, 1, c, 1, 0, 0, c + 1, 1);
      add(1, 1, 1, 12, 1, 0, 0, 0, 1);
      for (int c = 0; c < 15; c++)
         add(1, 0, 1, c, 1, 0, 0, c + 1, 1);
      // cnt_reset at all-ones: no wrap
      add(1, 1, 1, 15, 1, 0, 0, 0, 1);
      add(1, 0, 0, 0, 1, 0, 0, 0, 1);
      // second mismatch, relock, then reset while locked
      add(1, 0, 0, 3, 0, 1, 0, 3, 2);
      add(1, 0, 0, 3, 0, 0, 0, 3, 2);
      add(1, 0, 0, 3, 1, 0, 0, 3, 2);
      add(0, 0, 1, 3, 0, 0, 0, 0, 0);
      // full relock sequence; ACQUIRE miss is silent
      add(1, 0, 1, 5, 0, 0, 0, 6, 0);
      add(1, 0, 1, 9, 0, 0, 0, 10, 0);
      add(1, 0, 1, 10, 0, 0, 0, 11, 0);
      add(1, 0, 1, 11, 1, 0, 0, 12, 0);

      foreach (tv[i]) begin
         reset = tv[i].rst; cnt_reset = tv[i].cr;
         enable = tv[i].en; count = tv[i].cnt;
         @(posedge clk);
         #1;
         cmp("locked", i, int'(locked), int'(tv[i].lk));
         cmp("mismatch", i, int'(mismatch), int'(tv[i].mm));
         cmp("wrap", i, int'(wrap), int'(tv[i].wr));
         cmp("expected", i, int'(expected), int'(tv[i].ex));
         cmp("err_count", i, int'(err_count), tv[i].er);
      end

      // saturation on a 2-bit error counter
      step2(0, 0, 0, 0);
      cmp("sat_reset", 0, int'(err_count2), 0);
      step2(1, 0, 0, 0);
      step2(1, 0, 0, 0);
      step2(1, 0, 0, 0);
      cmp("sat_lock", 0, int'(locked2), 1);
      for (int k = 1; k <= 6; k++) begin
         step2(1, 0, 0, k);
         cmp("sat_mm", k, int'(mismatch2), 1);
         cmp("sat_err", k, int'(err_count2), (k > 3) ? 3 : k);
         step2(1, 0, 0, k);
         cmp("sat_pulse", k, int'(mismatch2), 0);
         step2(1, 0, 0, k);
         cmp("sat_relock", k, int'(locked2), 1);
      end
      step2(1, 0, 0, 6);
      cmp("sat_hold", 0, int'(err_count2), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
